// File: rtl/nmi_bus_arb_if.sv
// rtl/nmi_bus_arb_if.sv - native memory interface (NMI) bundle with master/slave views
interface nmi_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, output addr, output wdata, output wstrb,
                  input ready, input rdata);
  modport slave  (input valid, input addr, input wdata, input wstrb,
                  output ready, output rdata);
endinterface

// File: rtl/nmi_bus_arb.sv
// rtl/nmi_bus_arb.sv - round-robin CPU/DMA arbiter onto one NMI slave port with bus-timeout responder
module nmi_bus_arb #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  nmi_if.slave        cpu_nmi,
  nmi_if.slave        dma_nmi,
  nmi_if.master       nmi,
  output logic        timeout_o,
  output logic [31:0] err_addr_o,
  output logic [7:0]  err_cnt_o
);

  typedef enum logic [1:0] {IDLE, GNT, ERR} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state_q, state_d;
  logic        gnt_sel_q;
  logic        rr_ptr_q;
  logic [15:0] tmo_cnt_q;

  logic        pick_sel;
  logic        gnt_valid;
  logic [31:0] gnt_addr;
  logic [31:0] gnt_wdata;
  logic [3:0]  gnt_wstrb;
  logic        done;
  logic        tmo_hit;
  logic        resp_ready;
  logic [31:0] resp_rdata;

  // gnt_sel: 0 = CPU, 1 = DMA
  always_comb begin
    gnt_valid = gnt_sel_q ? dma_nmi.valid : cpu_nmi.valid;
    gnt_addr  = gnt_sel_q ? dma_nmi.addr  : cpu_nmi.addr;
    gnt_wdata = gnt_sel_q ? dma_nmi.wdata : cpu_nmi.wdata;
    gnt_wstrb = gnt_sel_q ? dma_nmi.wstrb : cpu_nmi.wstrb;
    pick_sel  = (cpu_nmi.valid && dma_nmi.valid) ? rr_ptr_q : dma_nmi.valid;
    done      = (state_q == GNT) && gnt_valid && nmi.ready;
    tmo_hit   = (state_q == GNT) && gnt_valid && !nmi.ready && (tmo_cnt_q == TMO_LAST);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      gnt_sel_q  <= 1'b0;
      rr_ptr_q   <= 1'b0;
      tmo_cnt_q  <= '0;
      timeout_o  <= 1'b0;
      err_addr_o <= '0;
      err_cnt_o  <= '0;
    end else begin
      state_q   <= state_d;
      timeout_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (state_d == GNT) begin
            gnt_sel_q <= pick_sel;
            tmo_cnt_q <= '0;
          end
        end
        GNT: begin
          if (done) begin
            rr_ptr_q <= ~gnt_sel_q;
          end else if (tmo_hit) begin
            // Logged on ERR entry so the ERR cycle already shows the new address and count.
            err_addr_o <= gnt_addr;
            timeout_o  <= 1'b1;
            if (err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
          end else if (gnt_valid) begin
            tmo_cnt_q <= tmo_cnt_q + 16'd1;
          end
        end
        ERR: rr_ptr_q <= ~gnt_sel_q;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cpu_nmi.valid || dma_nmi.valid) state_d = GNT;
      GNT: begin
        // A master dropping valid mid-transaction is abandoned silently.
        if (!gnt_valid)   state_d = IDLE;
        else if (done)    state_d = IDLE;
        else if (tmo_hit) state_d = ERR;
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    nmi.valid  = 1'b0;
    nmi.addr   = '0;
    nmi.wdata  = '0;
    nmi.wstrb  = '0;
    resp_ready = 1'b0;
    resp_rdata = '0;
    if (state_q == GNT) begin
      nmi.valid = gnt_valid;
      nmi.addr  = gnt_addr;
      nmi.wdata = gnt_wdata;
      nmi.wstrb = gnt_wstrb;
      if (done) begin
        resp_ready = 1'b1;
        resp_rdata = nmi.rdata;
      end
    end else if (state_q == ERR) begin
      resp_ready = 1'b1;
      resp_rdata = ERR_RDATA;
    end
  end

  always_comb begin
    cpu_nmi.ready = resp_ready && !gnt_sel_q;
    cpu_nmi.rdata = gnt_sel_q ? 32'h0 : resp_rdata;
    dma_nmi.ready = resp_ready && gnt_sel_q;
    dma_nmi.rdata = gnt_sel_q ? resp_rdata : 32'h0;
  end

endmodule
